sample_decimator: RTL and testbench

SAMPLE_DECIMATOR -- requirements
Module: sample_decimator

---
 rtl/sample_decimator.sv | 72 +++++++
 tb/tb_sample_decimator.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_decimator.sv
// Block-average decimator: sums N = 2^active_sel consecutive input samples and
// emits their floor average as one output strobe; freeze holds the display.
module sample_decimator #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int ACC_WIDTH    = SAMPLE_WIDTH + 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    new_sample_in,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic [1:0]              decim_sel,
  input  logic                    freeze,
  output logic                    new_sample_out,
  output logic [SAMPLE_WIDTH-1:0] sample_out,
  output logic [1:0]              active_sel
);

  typedef enum logic {RUN, FROZEN} state_t;

  state_t                       state;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic [2:0]                   count;
  logic signed [ACC_WIDTH-1:0]  sum_c;
  logic                         last_c;

  // Running sum including the sample strobed this cycle.
  assign sum_c  = acc + {{(ACC_WIDTH-SAMPLE_WIDTH){sample_in[SAMPLE_WIDTH-1]}}, sample_in};
  assign last_c = (count == 3'((4'd1 << active_sel) - 4'd1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= RUN;
      acc            <= '0;
      count          <= '0;
      sample_out     <= '0;
      new_sample_out <= 1'b0;
      active_sel     <= '0;
    end else begin
      new_sample_out <= 1'b0;
      case (state)
        RUN: begin
          if (freeze) begin
            // A sample coinciding with freeze is dropped along with the partial block.
            state <= FROZEN;
            acc   <= '0;
            count <= '0;
            if (count == 3'd0) active_sel <= decim_sel;
          end else if (new_sample_in) begin
            if (last_c) begin
              sample_out     <= SAMPLE_WIDTH'(sum_c >>> active_sel);
              new_sample_out <= 1'b1;
              acc            <= '0;
              count          <= '0;
              active_sel     <= decim_sel;
            end else begin
              acc   <= sum_c;
              count <= count + 3'd1;
            end
          end else if (count == 3'd0) begin
            active_sel <= decim_sel;
          end
        end
        FROZEN: begin
          active_sel <= decim_sel;
          if (!freeze) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_decimator.sv
// Self-checking bench for sample_decimator: directed scenarios plus a randomized
// run compared against a block-average reference model.
module tb_sample_decimator;

  logic        clk;
  logic        reset;
  logic        new_sample_in;
  logic [15:0] sample_in;
  logic [1:0]  decim_sel;
  logic        freeze;
  logic        new_sample_out;
  logic [15:0] sample_out;
  logic [1:0]  active_sel;

  int checks = 0;
  int errors = 0;

  sample_decimator #(.SAMPLE_WIDTH(16), .ACC_WIDTH(19)) dut (
    .clk(clk), .reset(reset), .new_sample_in(new_sample_in), .sample_in(sample_in),
    .decim_sel(decim_sel), .freeze(freeze), .new_sample_out(new_sample_out),
    .sample_out(sample_out), .active_sel(active_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: list of samples in the open block, expected outputs.
  int         blk[$];
  bit         m_frozen;
  int         exp_out;
  bit         exp_nso;
  logic [1:0] exp_sel;

  function automatic int fdiv(input int s, input int n);
    int q;
    q = s / n;
    if ((s % n) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    blk.delete();
    m_frozen = 1'b0;
    exp_out  = 0;
    exp_nso  = 1'b0;
    exp_sel  = 2'd0;
  endtask

  task automatic model_step(input bit st, input int val, input bit fr, input logic [1:0] ds);
    int sum;
    exp_nso = 1'b0;
    if (m_frozen) begin
      exp_sel = ds;
      if (!fr) m_frozen = 1'b0;
    end else if (fr) begin
      if (blk.size() == 0) exp_sel = ds;
      blk.delete();
      m_frozen = 1'b1;
    end else if (st) begin
      blk.push_back(val);
      if (blk.size() == (1 << exp_sel)) begin
        sum = 0;
        foreach (blk[i]) sum += blk[i];
        exp_out = fdiv(sum, 1 << exp_sel);
        exp_nso = 1'b1;
        blk.delete();
        exp_sel = ds;
      end
    end else if (blk.size() == 0) begin
      exp_sel = ds;
    end
  endtask

  // Drive one cycle of stimulus, advance the model, sample #1 after the edge.
  task automatic step(input bit st, input int val, input bit fr, input logic [1:0] ds);
    new_sample_in = st;
    sample_in     = 16'(val);
    freeze        = fr;
    decim_sel     = ds;
    model_step(st, val, fr, ds);
    @(posedge clk);
    #1;
    new_sample_in = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    new_sample_in = 1'b0; sample_in = '0; freeze = 1'b0; decim_sel = 2'd0;
    model_reset();
    #12;
    checks++;
    if (new_sample_out !== 1'b0 || sample_out !== 16'd0 || active_sel !== 2'd0) begin
      errors++;
      $display("FAIL reset: nso=%b out=%0d sel=%0d, required 0/0/0", new_sample_out, sample_out, active_sel);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_pass_through();
    int vals[3] = '{100, -5, 32767};
    step(1'b0, 0, 1'b0, 2'd0);
    foreach (vals[i]) begin
      step(1'b1, vals[i], 1'b0, 2'd0);
      checks++;
      if (new_sample_out !== 1'b1 || sample_out !== 16'(vals[i])) begin
        errors++;
        $display("FAIL pass_through[%0d]: nso=%b out=%0d, required 1/%0d", i, new_sample_out, $signed(sample_out), vals[i]);
      end
    end
    step(1'b0, 0, 1'b0, 2'd0);
    checks++;
    if (new_sample_out !== 1'b0) begin
      errors++;
      $display("FAIL pass_through_idle: nso=%b, required 0", new_sample_out);
    end
  endtask

  task automatic test_average4();
    int vals[4] = '{10, 20, 30, 41};
    step(1'b0, 0, 1'b0, 2'd2);
    foreach (vals[i]) begin
      step(1'b1, vals[i], 1'b0, 2'd2);
      checks++;
      if (new_sample_out !== (i == 3)) begin
        errors++;
        $display("FAIL avg4_strobe[%0d]: nso=%b, required %b", i, new_sample_out, i == 3);
      end
    end
    checks++;
    if (sample_out !== 16'd25) begin
      errors++;
      $display("FAIL avg4_value: out=%0d, required 25", $signed(sample_out));
    end
  endtask

  task automatic test_negative();
    step(1'b0, 0, 1'b0, 2'd3);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, -32768, 1'b0, 2'd3);
      checks++;
      if (new_sample_out !== (i == 7)) begin
        errors++;
        $display("FAIL neg8_strobe[%0d]: nso=%b, required %b", i, new_sample_out, i == 7);
      end
    end
    checks++;
    if (sample_out !== 16'h8000) begin
      errors++;
      $display("FAIL neg8_value: out=%0d, required -32768", $signed(sample_out));
    end
    step(1'b0, 0, 1'b0, 2'd1);
    step(1'b1, -1, 1'b0, 2'd1);
    step(1'b1, -2, 1'b0, 2'd1);
    checks++;
    if (new_sample_out !== 1'b1 || sample_out !== 16'hFFFE) begin
      errors++;
      $display("FAIL neg_floor: nso=%b out=%0d, required 1/-2", new_sample_out, $signed(sample_out));
    end
  endtask

  task automatic test_sel_change();
    step(1'b0, 0, 1'b0, 2'd2);
    step(1'b1, 1, 1'b0, 2'd2);
    step(1'b1, 2, 1'b0, 2'd2);
    step(1'b1, 3, 1'b0, 2'd0);
    checks++;
    if (active_sel !== 2'd2 || new_sample_out !== 1'b0) begin
      errors++;
      $display("FAIL sel_mid_block: sel=%0d nso=%b, required 2/0", active_sel, new_sample_out);
    end
    step(1'b1, 4, 1'b0, 2'd0);
    checks++;
    if (active_sel !== 2'd0 || new_sample_out !== 1'b1 || sample_out !== 16'd2) begin
      errors++;
      $display("FAIL sel_boundary: sel=%0d nso=%b out=%0d, required 0/1/2", active_sel, new_sample_out, $signed(sample_out));
    end
    for (int v = 5; v <= 6; v++) begin
      step(1'b1, v, 1'b0, 2'd0);
      checks++;
      if (new_sample_out !== 1'b1 || sample_out !== 16'(v)) begin
        errors++;
        $display("FAIL sel_after[%0d]: nso=%b out=%0d, required 1/%0d", v, new_sample_out, $signed(sample_out), v);
      end
    end
  endtask

  task automatic test_freeze();
    logic [15:0] held;
    held = 16'(exp_out);
    step(1'b0, 0, 1'b0, 2'd1);
    step(1'b1, 7, 1'b0, 2'd1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 9, 1'b1, 2'd1);
      checks++;
      if (new_sample_out !== 1'b0 || sample_out !== held) begin
        errors++;
        $display("FAIL freeze_hold[%0d]: nso=%b out=%0d, required 0/%0d", i, new_sample_out, $signed(sample_out), $signed(held));
      end
    end
    step(1'b0, 0, 1'b0, 2'd1);
    step(1'b1, 4, 1'b0, 2'd1);
    checks++;
    if (new_sample_out !== 1'b0) begin
      errors++;
      $display("FAIL freeze_resume_first: nso=%b, required 0", new_sample_out);
    end
    step(1'b1, 6, 1'b0, 2'd1);
    checks++;
    if (new_sample_out !== 1'b1 || sample_out !== 16'd5) begin
      errors++;
      $display("FAIL freeze_resume: nso=%b out=%0d, required 1/5", new_sample_out, $signed(sample_out));
    end
  endtask

  task automatic test_reset_mid_block();
    step(1'b0, 0, 1'b0, 2'd3);
    for (int i = 0; i < 3; i++) step(1'b1, 50, 1'b0, 2'd3);
    reset = 1'b1;
    model_reset();
    #2;
    checks++;
    if (new_sample_out !== 1'b0 || sample_out !== 16'd0 || active_sel !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid: nso=%b out=%0d sel=%0d, required 0/0/0", new_sample_out, sample_out, active_sel);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    step(1'b0, 0, 1'b0, 2'd3);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8, 1'b0, 2'd3);
      checks++;
      if (new_sample_out !== (i == 7)) begin
        errors++;
        $display("FAIL reset_block_strobe[%0d]: nso=%b, required %b", i, new_sample_out, i == 7);
      end
    end
    checks++;
    if (sample_out !== 16'd8) begin
      errors++;
      $display("FAIL reset_block_value: out=%0d, required 8", $signed(sample_out));
    end
  endtask

  task automatic test_random();
    bit         st, fr;
    int         val;
    logic [1:0] ds;
    ds = 2'd0;
    for (int c = 0; c < 3000; c++) begin
      st = ($urandom_range(0, 3) != 0);
      fr = ($urandom_range(0, 29) == 0) || (m_frozen && $urandom_range(0, 2) != 0);
      if ($urandom_range(0, 19) == 0) ds = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0:       val = -32768;
        1:       val = 32767;
        default: val = $signed(16'($urandom));
      endcase
      step(st, val, fr, ds);
      checks++;
      if (new_sample_out !== exp_nso || sample_out !== 16'(exp_out) || active_sel !== exp_sel) begin
        errors++;
        $display("FAIL random[%0d]: nso=%b out=%0d sel=%0d, required %b/%0d/%0d",
                 c, new_sample_out, $signed(sample_out), active_sel, exp_nso, exp_out, exp_sel);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_average4();
    test_negative();
    test_sel_change();
    test_freeze();
    test_reset_mid_block();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
